// File: rtl/mem_req_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Load/store has fixed priority; responses are returned as a one-cycle pulse to the owning master.
module mem_req_arbiter (
  input  logic        clock,
  input  logic        reset,

  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_inst,

  input  logic        ls_req_valid,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wstrb,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_rdata,

  output logic        mem_req_valid,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,

  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      r_state;
  logic        r_owner_ls;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic        r_if_resp_valid;
  logic [31:0] r_if_inst;
  logic        r_ls_resp_valid;
  logic [63:0] r_ls_rdata;
  logic        r_proto_err;

  logic        w_idle;
  logic        w_ls_acc;
  logic        w_if_acc;

  // Ready is gated by reset so nothing is accepted before the first edge with reset released.
  assign w_idle   = (r_state == IDLE) && reset;
  assign w_ls_acc = w_idle && ls_req_valid;
  assign w_if_acc = w_idle && if_req_valid && !ls_req_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_owner_ls      <= 1'b0;
      r_wen           <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_if_resp_valid <= 1'b0;
      r_if_inst       <= '0;
      r_ls_resp_valid <= 1'b0;
      r_ls_rdata      <= '0;
      r_proto_err     <= 1'b0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      if (mem_resp_valid && (r_state != WAIT)) r_proto_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_ls_acc) begin
            r_owner_ls <= 1'b1;
            r_wen      <= ls_req_wen;
            r_addr     <= ls_req_addr;
            r_wdata    <= ls_req_wdata;
            r_wstrb    <= ls_req_wstrb;
            r_state    <= ISSUE;
          end else if (w_if_acc) begin
            r_owner_ls <= 1'b0;
            r_wen      <= 1'b0;
            r_addr     <= if_req_addr;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (r_owner_ls) begin
              r_ls_rdata      <= mem_resp_rdata;
              r_ls_resp_valid <= 1'b1;
            end else begin
              r_if_inst       <= r_addr[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
              r_if_resp_valid <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ls_req_ready  = w_ls_acc;
  assign if_req_ready  = w_if_acc;

  assign mem_req_valid = (r_state == ISSUE);
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;

  assign if_resp_valid = r_if_resp_valid;
  assign if_resp_inst  = r_if_inst;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_resp_rdata = r_ls_rdata;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: behavioural memory with programmable delays,
// expected responses queued at request acceptance and checked when the pulse appears.
module tb_mem_req_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        ls_req_valid;
  logic        ls_req_wen;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wstrb;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        proto_err;

  mem_req_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .proto_err(proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] if_q[$];
  logic [63:0] ls_q[$];
  logic [63:0] last_if = '0;
  logic [63:0] last_ls = '0;

  int          ready_dly  = 0;
  int          resp_dly   = 0;
  bit          force_resp = 0;
  int          m_phase;
  int          m_cnt;
  logic [63:0] m_addr;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    logic [31:0] dw;
    dw = {a[31:3], 3'b000};
    if (dw == 32'h8000_0000) return 64'h00000013_00100093;
    return {dw ^ 32'hA5A5_0000, dw ^ 32'h0000_5A5A};
  endfunction

  // Memory model: drives its outputs 1 time unit after each rising edge.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    m_phase = 0;
    m_cnt   = 0;
    m_addr  = '0;
    forever begin
      @(posedge clock);
      #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = force_resp;
      if (force_resp) mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (!reset) begin
        m_phase = 0;
        m_cnt   = 0;
      end else if (m_phase == 0) begin
        if (mem_req_valid === 1'b1) begin
          if (m_cnt >= ready_dly) begin
            mem_req_ready = 1'b1;
            m_addr  = mem_req_addr;
            m_phase = 1;
            m_cnt   = 0;
          end else m_cnt++;
        end
      end else begin
        if (m_cnt >= resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem_data(m_addr);
          m_phase = 0;
          m_cnt   = 0;
        end else m_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check any response pulse against the scoreboard.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    if (reset) begin
      if (if_resp_valid === 1'b1) begin
        n_tests++;
        assert (if_q.size() != 0) else begin
          n_fail++;
          $error("FAIL if_resp_unexpected observed=pulse expected=none");
        end
        if (if_q.size() != 0) begin
          last_if = if_q.pop_front();
          chk("if_resp_inst", {32'h0, if_resp_inst}, last_if);
        end
      end else chk("if_inst_hold", {32'h0, if_resp_inst}, last_if);
      if (ls_resp_valid === 1'b1) begin
        n_tests++;
        assert (ls_q.size() != 0) else begin
          n_fail++;
          $error("FAIL ls_resp_unexpected observed=pulse expected=none");
        end
        if (ls_q.size() != 0) begin
          last_ls = ls_q.pop_front();
          chk("ls_resp_rdata", ls_resp_rdata, last_ls);
        end
      end else chk("ls_rdata_hold", ls_resp_rdata, last_ls);
    end
  endtask

  task automatic do_req(input bit is_ls, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb);
    bit          acc;
    logic [63:0] dw;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_req_wen = wen; ls_req_addr = addr;
      ls_req_wdata = wdata; ls_req_wstrb = wstrb;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      if ((is_ls ? ls_req_ready : if_req_ready) === 1'b1) begin
        acc = 1;
        dw  = mem_data(addr);
        if (is_ls) ls_q.push_back(dw);
        else       if_q.push_back(addr[2] ? {32'h0, dw[63:32]} : {32'h0, dw[31:0]});
      end
      cyc();
    end
    if (is_ls) ls_req_valid = 1'b0;
    else       if_req_valid = 1'b0;
    n_tests++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL req_accept_timeout observed=0 expected=1 addr=%h", addr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (if_q.size() != 0 || ls_q.size() != 0); i++) cyc();
    n_tests++;
    assert (if_q.size() == 0 && ls_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout observed=%0d/%0d pending expected=0/0", if_q.size(), ls_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_ls_req_ready"},  ls_req_ready, 0);
    chk({tag, "_if_req_ready"},  if_req_ready, 0);
    chk({tag, "_if_resp_valid"}, if_resp_valid, 0);
    chk({tag, "_ls_resp_valid"}, ls_resp_valid, 0);
    chk({tag, "_if_resp_inst"},  {32'h0, if_resp_inst}, 0);
    chk({tag, "_ls_resp_rdata"}, ls_resp_rdata, 0);
    chk({tag, "_mem_req_addr"},  mem_req_addr, 0);
    chk({tag, "_proto_err"},     proto_err, 0);
  endtask

  initial begin
    bit got;
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_1000;
    ls_req_wdata = '0; ls_req_wstrb = '0;

    // Reset: requests asserted but nothing may be accepted.
    @(negedge clock);
    @(negedge clock);
    chk_reset_outputs("rst");
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    reset = 1'b1;
    cyc();

    // Single fetch with an immediately-ready memory: response three cycles after acceptance.
    do_req(0, 1'b0, 64'h8000_0004, '0, '0);
    chk("f1_mem_req_valid_t1", mem_req_valid, 1);
    chk("f1_mem_req_addr", mem_req_addr, 64'h8000_0004);
    chk("f1_mem_req_wen", mem_req_wen, 0);
    chk("f1_mem_req_wstrb", {56'h0, mem_req_wstrb}, 0);
    chk("f1_mem_req_wdata", mem_req_wdata, 0);
    cyc();
    chk("f1_mem_req_valid_t2", mem_req_valid, 0);
    chk("f1_resp_valid_t2", if_resp_valid, 0);
    cyc();
    chk("f1_resp_valid_t3", if_resp_valid, 1);
    chk("f1_inst", {32'h0, if_resp_inst}, 64'h0000_0013);
    cyc();
    chk("f1_resp_pulse_end", if_resp_valid, 0);

    // Simultaneous requests: load wins, fetch is taken in the cycle the load response pulses.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_1000;
    #1;
    chk("sim_ls_ready", ls_req_ready, 1);
    chk("sim_if_ready", if_req_ready, 0);
    ls_q.push_back(mem_data(64'h8000_1000));
    cyc();
    ls_req_valid = 1'b0;
    chk("sim_mem_req_addr", mem_req_addr, 64'h8000_1000);
    chk("sim_mem_req_wen", mem_req_wen, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if_req_ready === 1'b1) begin
        got = 1;
        chk("sim_fetch_with_ls_resp", ls_resp_valid, 1);
        if_q.push_back({32'h0, mem_data(64'h8000_0008)[31:0]});
      end
      cyc();
    end
    if_req_valid = 1'b0;
    chk("sim_fetch_accepted", got, 1);
    drain();

    // Store held off by memory for three cycles: request fields must stay put.
    ready_dly = 3;
    do_req(1, 1'b1, 64'h8000_2000, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      chk("st_valid", mem_req_valid, 1);
      chk("st_wen", mem_req_wen, 1);
      chk("st_addr", mem_req_addr, 64'h8000_2000);
      chk("st_wdata", mem_req_wdata, 64'h0000_0000_DEAD_BEEF);
      chk("st_wstrb", {56'h0, mem_req_wstrb}, 64'h0F);
      cyc();
    end
    chk("st_valid_after_ready", mem_req_valid, 0);
    ready_dly = 0;
    drain();

    // Spurious memory response in IDLE.
    force_resp = 1;
    cyc();
    force_resp = 0;
    chk("spur_proto_before", proto_err, 0);
    cyc();
    chk("spur_proto_set", proto_err, 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("spur_proto_sticky", proto_err, 1);

    // Four back-to-back fetches against a two-cycle memory.
    resp_dly = 1;
    for (int k = 0; k < 4; k++) do_req(0, 1'b0, 64'h8000_0000 + 64'(4 * k), '0, '0);
    drain();
    resp_dly = 0;

    // Asynchronous reset while the request is stalled in ISSUE.
    ready_dly = 20;
    do_req(0, 1'b0, 64'h8000_0018, '0, '0);
    cyc();
    chk("rst_issue_valid_before", mem_req_valid, 1);
    reset = 1'b0;
    #1;
    chk("rst_issue_valid_after", mem_req_valid, 0);
    chk("rst_issue_addr_after", mem_req_addr, 0);
    if_q.delete(); ls_q.delete();
    last_if = '0; last_ls = '0;
    cyc();
    reset = 1'b1;
    ready_dly = 0;
    cyc();

    // Asynchronous reset in WAIT, then a fresh fetch.
    resp_dly = 8;
    do_req(0, 1'b0, 64'h8000_0010, '0, '0);
    cyc();
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3000;
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    if_q.delete(); ls_q.delete();
    last_if = '0; last_ls = '0;
    ls_req_valid = 1'b0;
    cyc();
    reset = 1'b1;
    resp_dly = 0;
    cyc();
    do_req(0, 1'b0, 64'h8000_0014, '0, '0);
    drain();
    chk("post_rst_proto", proto_err, 0);
    chk("post_rst_last_inst", {32'h0, if_resp_inst}, {32'h0, mem_data(64'h8000_0014)[63:32]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed in REQ-002..REQ-006.
REQ-002 It SHALL provide these clock and reset ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-003 It SHALL provide these fetch-side ports:
- if_req_valid  in  1  fetch request.
- if_req_addr  in  64  fetch PC; bits [1:0] are always 0.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  one-cycle pulse; instruction returned.
- if_resp_inst  out  32  returned instruction word.
REQ-004 It SHALL provide these load/store-side ports:
- ls_req_valid  in  1  load/store request.
- ls_req_wen  in  1  1 = store, 0 = load.
- ls_req_addr  in  64  data address.
- ls_req_wdata  in  64  store data.
- ls_req_wstrb  in  8  store byte mask.
- ls_req_ready  out  1  request accepted this cycle.
- ls_resp_valid  out  1  one-cycle pulse; load data returned or store acknowledged.
- ls_resp_rdata  out  64  load data.
REQ-005 It SHALL provide these memory-side ports:
- mem_req_valid  out  1  request to memory.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  64  address.
- mem_req_wdata  out  64  write data.
- mem_req_wstrb  out  8  byte mask.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  64  memory read data.
REQ-006 It SHALL provide a status port:
- proto_err  out  1  sticky protocol-error flag.

Function
REQ-007 The arbiter SHALL allow at most one outstanding memory transaction, using FSM states IDLE, ISSUE and WAIT.
REQ-008 In IDLE, ls_req_ready SHALL equal ls_req_valid.
REQ-009 In IDLE, if_req_ready SHALL equal if_req_valid & ~ls_req_valid, so load/store has fixed priority.
REQ-010 In ISSUE and WAIT, both ready outputs SHALL be 0.
REQ-011 On an accepted request, the block SHALL latch owner, wen, addr, wdata and wstrb, then move IDLE->ISSUE.
- Fetch requests latch wen=0, wdata=0, wstrb=0x00.
REQ-012 In ISSUE, mem_req_valid SHALL be 1 and mem_req_* SHALL show the latched fields, held stable until mem_req_ready.
- On mem_req_ready, the FSM moves ISSUE->WAIT.
REQ-013 In IDLE and WAIT, mem_req_valid SHALL be 0.
REQ-014 In WAIT, on mem_resp_valid the block SHALL register the response, move WAIT->IDLE, and assert the owner's resp_valid for exactly the next cycle.
REQ-015 For a fetch response, if_resp_inst SHALL be mem_resp_rdata[63:32] when latched addr[2]=1, else mem_resp_rdata[31:0].
REQ-016 For a load/store response, ls_resp_rdata SHALL be mem_resp_rdata; stores also receive one ls_resp_valid pulse as their acknowledge.
REQ-017 Response data outputs SHALL hold their last value while resp_valid is 0.
REQ-018 Minimum latency SHALL be: accept at cycle t, mem_req_valid at t+1, response at t+2 if memory is ready immediately, resp_valid at t+3.
- The next request can be accepted at t+3, the same cycle as resp_valid.
REQ-019 If mem_resp_valid=1 in IDLE or ISSUE, the block SHALL ignore it and set proto_err=1 from the next cycle until reset.
REQ-020 Request inputs SHALL be ignored while state is not IDLE; masters keep valid asserted until they see ready.

Reset
REQ-021 While reset=0, the FSM SHALL be forced to IDLE immediately (asynchronously).
REQ-022 While reset=0, all outputs SHALL be 0: ready, resp_valid, mem_req_*, response data and proto_err.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; a memory response arriving after release is treated per REQ-019.
REQ-024 After reset release, the first request SHALL be accepted no earlier than the first rising edge with reset=1.

Verification
REQ-025 Fetch with immediate memory: if_req_valid=1, addr=0x80000004; mem ready; rdata=0x00000013_00100093 -> if_resp_valid pulse at t+3 with inst=0x00000013.
REQ-026 Simultaneous requests: if_req_valid=1 and ls_req_valid=1 (load, 0x80001000) -> ls_req_ready=1, if_req_ready=0; mem_req_addr=0x80001000.
- The fetch is accepted in the cycle ls_resp_valid pulses.
REQ-027 Store with backpressure: wen=1, wdata=0xDEADBEEF, wstrb=0x0F; mem_req_ready low for 3 cycles -> mem_req_* stable for 4 cycles, then one ls_resp_valid pulse after mem_resp_valid.
REQ-028 Spurious response: mem_resp_valid=1 in IDLE -> no resp_valid on either side; proto_err=1 next cycle and stays 1.
REQ-029 Async reset in WAIT: drop reset=0 between edges -> mem_req_valid, ready and resp outputs read 0 immediately; after release, a fresh fetch completes normally.
REQ-030 Back-to-back fetches: 4 consecutive fetches at PC 0x80000000, +4, +8, +0xC with 2-cycle memory -> 4 resp pulses with correct word halves, no dropped or duplicated response.
